// File: rtl/binary_div_9_5_bi.sv
// Sequential signed restoring divider: 9-bit dividend / 5-bit divisor, one quotient bit per enabled clock.
// Optional divide-by-zero short-cut and dz flag enabled by defining BINARY_DIV_ZERO_CHECK_EN.
module binary_div_9_5_bi (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic [8:0] N,
  input  logic [4:0] D,
  output logic [9:0] Q,
  output logic [4:0] R,
  output logic       busy,
  output logic       done,
  output logic       dz
);

  // state | meaning
  // IDLE  | waiting for start
  // CALC  | one restoring step per enabled edge, 9 steps
  // FIN   | result valid, done pulse; start here is accepted
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] nsh_q, nsh_d;
  logic [4:0] dabs_q, dabs_d;
  logic [5:0] prem_q, prem_d;
  logic [8:0] qmag_q, qmag_d;
  logic       sq_q, sq_d;
  logic       sr_q, sr_d;
  logic [9:0] q_q, q_d;
  logic [4:0] r_q, r_d;

  logic [5:0] shifted;
  logic [6:0] trial;
  logic       qbit;
  logic [5:0] rem_next;
  logic [8:0] qmag_next;

  // Partial remainder never exceeds 2*15+1, so 6 bits plus a borrow bit suffice.
  assign shifted   = {prem_q[4:0], nsh_q[8]};
  assign trial     = {1'b0, shifted} - {2'b00, dabs_q};
  assign qbit      = ~trial[6];
  assign rem_next  = qbit ? trial[5:0] : shifted;
  assign qmag_next = {qmag_q[7:0], qbit};

`ifdef BINARY_DIV_ZERO_CHECK_EN
  logic dz_q, dz_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nsh_d   = nsh_q;
    dabs_d  = dabs_q;
    prem_d  = prem_q;
    qmag_d  = qmag_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef BINARY_DIV_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif
    if (en) begin
      case (state_q)
        CALC: begin
          nsh_d  = {nsh_q[7:0], 1'b0};
          prem_d = rem_next;
          qmag_d = qmag_next;
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            state_d = FIN;
            cnt_d   = 4'd0;
            q_d     = sq_q ? (~{1'b0, qmag_next} + 10'd1) : {1'b0, qmag_next};
            r_d     = sr_q ? (~rem_next[4:0] + 5'd1) : rem_next[4:0];
`ifdef BINARY_DIV_ZERO_CHECK_EN
            dz_d    = 1'b0;
`endif
          end
        end
        default: begin
          if (state_q == FIN) state_d = IDLE;
          if (start) begin
            nsh_d   = N[8] ? (~N + 9'd1) : N;
            dabs_d  = D[4] ? (~D + 5'd1) : D;
            sq_d    = N[8] ^ D[4];
            sr_d    = N[8];
            prem_d  = 6'd0;
            qmag_d  = 9'd0;
            cnt_d   = 4'd8;
            state_d = CALC;
`ifdef BINARY_DIV_ZERO_CHECK_EN
            if (D == 5'd0) begin
              state_d = FIN;
              cnt_d   = 4'd0;
              q_d     = 10'd0;
              r_d     = 5'd0;
              dz_d    = 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      nsh_q   <= 9'd0;
      dabs_q  <= 5'd0;
      prem_q  <= 6'd0;
      qmag_q  <= 9'd0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      q_q     <= 10'd0;
      r_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nsh_q   <= nsh_d;
      dabs_q  <= dabs_d;
      prem_q  <= prem_d;
      qmag_q  <= qmag_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

`ifdef BINARY_DIV_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dz_q <= 1'b0;
    else        dz_q <= dz_d;
  end
  assign dz = dz_q;
`else
  assign dz = 1'b0;
`endif

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = (state_q == CALC);
  assign done = (state_q == FIN);

endmodule
